// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared DSP datapath types and saturation helpers
// Contents: op_t update opcodes, state_t output stage states,
//           sat_max/sat_min full-scale bounds as 64-bit patterns (use low w bits).
package dsp_pkg;

  typedef enum logic [1:0] {
    OP_ACC    = 2'b00,
    OP_LOAD   = 2'b01,
    OP_ABSACC = 2'b10,
    OP_SUB    = 2'b11
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Positive full scale of a w-bit two's complement value (w <= 64).
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Negative full scale; only the low w bits are meaningful.
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/accum_alu.sv
// rtl/accum_alu.sv - combinational accumulator update with overflow detect
// Ports: acc, sample (W, signed) and op in; result (W) and ovf out.
//        SAT=1 clamps an out-of-range result, SAT=0 keeps the low W bits.
module accum_alu
  import dsp_pkg::*;
#(
  parameter int W   = 32,
  parameter int SAT = 1
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] sample,
  input  op_t          op,
  output logic [W-1:0] result,
  output logic         ovf
);

  localparam logic [63:0]  MAX64 = sat_max(W);
  localparam logic [63:0]  MIN64 = sat_min(W);
  localparam logic [W-1:0] MAX_V = MAX64[W-1:0];
  localparam logic [W-1:0] MIN_V = MIN64[W-1:0];

  // Two guard bits cover acc + |sample| and the negation of the most
  // negative sample without any intermediate wrap.
  logic signed [W+1:0] a;
  logic signed [W+1:0] b;
  logic signed [W+1:0] r;

  always_comb begin
    a = {{2{acc[W-1]}}, acc};
    b = {{2{sample[W-1]}}, sample};
    r = a + b;
    unique case (op)
      OP_ACC:    r = a + b;
      OP_LOAD:   r = b;
      OP_ABSACC: r = a + (b[W+1] ? -b : b);
      OP_SUB:    r = a - b;
      default:   r = a + b;
    endcase
  end

  always_comb begin
    // In range exactly when the top three bits agree.
    ovf    = (r[W+1:W-1] != 3'b000) && (r[W+1:W-1] != 3'b111);
    result = r[W-1:0];
    if (ovf && (SAT != 0)) begin
      result = r[W+1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/accum_bank.sv
// rtl/accum_bank.sv - N-channel signed accumulator bank with dump readout
// Ports: clk, reset (sync, active-high);
//        update: in_valid, in_ch, in_op, in_data;
//        dump request: dump_req, dump_ch, dump_ready;
//        result: out_valid, out_ready, out_ch, out_data, out_ovf.
module accum_bank
  import dsp_pkg::*;
#(
  parameter int W    = 32,
  parameter int N    = 4,
  parameter int SAT  = 1,
  localparam int CH_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [CH_W-1:0] in_ch,
  input  logic [1:0]      in_op,
  input  logic [W-1:0]    in_data,
  input  logic            dump_req,
  input  logic [CH_W-1:0] dump_ch,
  output logic            dump_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH_W-1:0] out_ch,
  output logic [W-1:0]    out_data,
  output logic            out_ovf
);

  // Register array rather than RAM: reset must clear every channel at once.
  logic [W-1:0] acc [N];
  logic         ovf [N];

  state_t state;
  state_t state_nxt;

  logic         dump_fire;
  logic         dump_hit;
  logic         upd_hit;
  logic         collide;
  logic [W-1:0] dump_acc;
  logic         dump_ovf;
  logic [W-1:0] alu_acc;
  logic         base_ovf;
  logic [W-1:0] alu_result;
  logic         alu_ovf;

  assign out_valid  = (state == ST_HOLD);
  assign dump_ready = !out_valid || out_ready;
  assign dump_fire  = dump_req && dump_ready;
  assign dump_hit   = 32'(dump_ch) < N;
  assign upd_hit    = in_valid && (32'(in_ch) < N);
  assign collide    = dump_fire && dump_hit && (dump_ch == in_ch);

  assign dump_acc = dump_hit ? acc[dump_ch] : '0;
  assign dump_ovf = dump_hit ? ovf[dump_ch] : 1'b0;

  // A same-cycle dump of the updated channel clears first, so the update
  // starts from zero with a cleared flag.
  assign alu_acc  = (collide || !upd_hit) ? '0 : acc[in_ch];
  assign base_ovf = (collide || !upd_hit) ? 1'b0 : ovf[in_ch];

  accum_alu #(
    .W   (W),
    .SAT (SAT)
  ) u_alu (
    .acc    (alu_acc),
    .sample (in_data),
    .op     (op_t'(in_op)),
    .result (alu_result),
    .ovf    (alu_ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (dump_fire) begin
      state_nxt = ST_HOLD;
    end else if ((state == ST_HOLD) && out_ready) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ch   <= '0;
      out_ovf  <= 1'b0;
    end else if (dump_fire) begin
      out_data <= dump_acc;
      out_ch   <= dump_ch;
      out_ovf  <= dump_ovf;
    end
  end

  // Later assignment wins, so the update overrides the dump clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
        ovf[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (dump_fire && dump_hit && (dump_ch == CH_W'(i))) begin
          acc[i] <= '0;
          ovf[i] <= 1'b0;
        end
        if (upd_hit && (in_ch == CH_W'(i))) begin
          acc[i] <= alu_result;
          ovf[i] <= base_ovf || alu_ovf;
        end
      end
    end
  end

endmodule

// File: tb/tb_accum_bank.sv
// tb/tb_accum_bank.sv - directed self-checking bench for accum_bank
module tb_accum_bank;

  localparam logic [1:0] OP_ACC    = 2'b00;
  localparam logic [1:0] OP_LOAD   = 2'b01;
  localparam logic [1:0] OP_ABSACC = 2'b10;
  localparam logic [1:0] OP_SUB    = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  in_ch;
  logic [1:0]  in_op;
  logic [31:0] in_data;
  logic        dump_req;
  logic [1:0]  dump_ch;
  logic        out_ready;

  logic        dump_ready, out_valid, out_ovf;
  logic [1:0]  out_ch;
  logic [31:0] out_data;
  logic        w_dump_ready, w_out_valid, w_out_ovf;
  logic [1:0]  w_out_ch;
  logic [31:0] w_out_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  accum_bank #(.W(32), .N(4), .SAT(1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ch(in_ch), .in_op(in_op), .in_data(in_data),
    .dump_req(dump_req), .dump_ch(dump_ch), .dump_ready(dump_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_data(out_data), .out_ovf(out_ovf)
  );

  accum_bank #(.W(32), .N(4), .SAT(0)) dut_wrap (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ch(in_ch), .in_op(in_op), .in_data(in_data),
    .dump_req(dump_req), .dump_ch(dump_ch), .dump_ready(w_dump_ready),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_ch(w_out_ch), .out_data(w_out_data), .out_ovf(w_out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [1:0] ch, input logic [1:0] op, input logic [31:0] data);
    in_valid = 1'b1;
    in_ch    = ch;
    in_op    = op;
    in_data  = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_dump(input logic [1:0] ch, output logic [31:0] d, output logic o,
                         output logic [1:0] c, output logic [31:0] wd, output logic wo);
    int n;
    dump_ch   = ch;
    dump_req  = 1'b1;
    out_ready = 1'b1;
    n = 0;
    while (!dump_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL dump_wait: dump_ready=%0b after %0d cycles, required 1", dump_ready, n);
    end
    tick();
    dump_req = 1'b0;
    d  = out_data;
    o  = out_ovf;
    c  = out_ch;
    wd = w_out_data;
    wo = w_out_ovf;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_ch = '0; in_op = '0; in_data = '0;
    dump_req = 1'b0; dump_ch = '0; out_ready = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, required 0", out_data); end
    checks++; if (out_ch !== 2'd0 || out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ch_ovf: got ch=%0d ovf=%0b, required 0/0", out_ch, out_ovf); end
    checks++; if (dump_ready !== 1'b1) begin errors++; $display("FAIL reset_dump_ready: got %0b, required 1", dump_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] d, wd; logic o, wo; logic [1:0] c;
    do_op(2'd0, OP_ACC, 32'd1);
    do_op(2'd0, OP_ACC, 32'd1);
    do_op(2'd0, OP_ACC, 32'hF0);
    do_dump(2'd0, d, o, c, wd, wo);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0b, required 1", out_valid); end
    checks++; if (d !== 32'h000000F2 || o !== 1'b0 || c !== 2'd0) begin errors++; $display("FAIL basic_dump: got %h/%0b/ch%0d, required 000000f2/0/ch0", d, o, c); end
    do_dump(2'd0, d, o, c, wd, wo);
    checks++; if (d !== 32'h0 || o !== 1'b0) begin errors++; $display("FAIL basic_redump: got %h/%0b, required 0/0", d, o); end
  endtask

  task automatic test_ops();
    logic [31:0] d, wd; logic o, wo; logic [1:0] c;
    do_op(2'd2, OP_LOAD, 32'h00001234);
    do_op(2'd2, OP_SUB,  32'h00001235);
    do_dump(2'd2, d, o, c, wd, wo);
    checks++; if (d !== 32'hFFFFFFFF || o !== 1'b0 || c !== 2'd2) begin errors++; $display("FAIL ops_sub: got %h/%0b/ch%0d, required ffffffff/0/ch2", d, o, c); end
    do_op(2'd2, OP_ABSACC, 32'hFFFFEDCB);
    do_dump(2'd2, d, o, c, wd, wo);
    checks++; if (d !== 32'h00001235 || o !== 1'b0) begin errors++; $display("FAIL ops_absacc: got %h/%0b, required 00001235/0", d, o); end
  endtask

  task automatic test_saturation();
    logic [31:0] d, wd; logic o, wo; logic [1:0] c;
    do_op(2'd1, OP_LOAD, 32'h7FFFFFF0);
    do_op(2'd1, OP_ACC,  32'h00000020);
    do_dump(2'd1, d, o, c, wd, wo);
    checks++; if (d !== 32'h7FFFFFFF || o !== 1'b1) begin errors++; $display("FAIL sat_acc: got %h/%0b, required 7fffffff/1", d, o); end
    checks++; if (wd !== 32'h80000010 || wo !== 1'b1) begin errors++; $display("FAIL wrap_acc: got %h/%0b, required 80000010/1", wd, wo); end
    do_op(2'd3, OP_ABSACC, 32'h80000000);
    do_dump(2'd3, d, o, c, wd, wo);
    checks++; if (d !== 32'h7FFFFFFF || o !== 1'b1) begin errors++; $display("FAIL sat_absmin: got %h/%0b, required 7fffffff/1", d, o); end
    checks++; if (wd !== 32'h80000000 || wo !== 1'b1) begin errors++; $display("FAIL wrap_absmin: got %h/%0b, required 80000000/1", wd, wo); end
    // Negative-side clamp, then LOAD must keep the sticky flag.
    do_op(2'd0, OP_LOAD, 32'h80000005);
    do_op(2'd0, OP_SUB,  32'h00000010);
    do_op(2'd0, OP_LOAD, 32'h00000005);
    do_dump(2'd0, d, o, c, wd, wo);
    checks++; if (d !== 32'h00000005 || o !== 1'b1) begin errors++; $display("FAIL load_keeps_ovf: got %h/%0b, required 00000005/1", d, o); end
    do_op(2'd0, OP_LOAD, 32'h80000005);
    do_op(2'd0, OP_SUB,  32'h00000010);
    do_dump(2'd0, d, o, c, wd, wo);
    checks++; if (d !== 32'h80000000 || wd !== 32'h7FFFFFF5) begin errors++; $display("FAIL sat_neg: got sat=%h wrap=%h, required 80000000/7ffffff5", d, wd); end
  endtask

  task automatic test_collision();
    logic [31:0] d, wd; logic o, wo; logic [1:0] c;
    do_op(2'd1, OP_LOAD, 32'd5);
    out_ready = 1'b1;
    dump_ch = 2'd1; dump_req = 1'b1;
    in_valid = 1'b1; in_ch = 2'd1; in_op = OP_ACC; in_data = 32'd3;
    tick();
    dump_req = 1'b0; in_valid = 1'b0;
    checks++; if (out_data !== 32'd5 || out_valid !== 1'b1) begin errors++; $display("FAIL collide_pre: got %h/v%0b, required 00000005/v1", out_data, out_valid); end
    do_dump(2'd1, d, o, c, wd, wo);
    checks++; if (d !== 32'd3 || o !== 1'b0) begin errors++; $display("FAIL collide_post: got %h/%0b, required 00000003/0", d, o); end
  endtask

  task automatic test_backpressure();
    do_op(2'd0, OP_LOAD, 32'd7);
    do_op(2'd3, OP_LOAD, 32'd9);
    out_ready = 1'b0;
    dump_ch = 2'd0; dump_req = 1'b1;
    tick();
    dump_ch = 2'd3;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dump_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'd7 || out_ch !== 2'd0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%0b v=%0b d=%h ch=%0d, required 0/1/00000007/0", i, dump_ready, out_valid, out_data, out_ch);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (dump_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_comb: got %0b, required 1", dump_ready); end
    tick();
    dump_req = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 32'd9) begin errors++; $display("FAIL bp_b2b: got v=%0b ch=%0d d=%h, required 1/3/00000009", out_valid, out_ch, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0b, required 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d, wd; logic o, wo; logic [1:0] c;
    do_op(2'd0, OP_LOAD, 32'd11);
    do_op(2'd1, OP_LOAD, 32'h7FFFFFFF);
    do_op(2'd1, OP_ACC,  32'd1);
    do_op(2'd2, OP_LOAD, 32'd33);
    do_op(2'd3, OP_LOAD, 32'd44);
    out_ready = 1'b0;
    dump_ch = 2'd2; dump_req = 1'b1;
    tick();
    dump_ch = 2'd3;
    reset = 1'b1;
    in_valid = 1'b1; in_ch = 2'd0; in_op = OP_LOAD; in_data = 32'd99;
    tick();
    reset = 1'b0; in_valid = 1'b0; dump_req = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_ch !== 2'd0 || out_ovf !== 1'b0) begin errors++; $display("FAIL rst_mid_out: got v=%0b d=%h ch=%0d ovf=%0b, required all 0", out_valid, out_data, out_ch, out_ovf); end
    for (int i = 0; i < 4; i++) begin
      do_dump(2'(i), d, o, c, wd, wo);
      checks++;
      if (d !== 32'h0 || o !== 1'b0 || wd !== 32'h0 || wo !== 1'b0 || c !== 2'(i)) begin
        errors++;
        $display("FAIL rst_mid_ch%0d: got d=%h o=%0b wd=%h wo=%0b ch=%0d, required 0/0/0/0/%0d", i, d, o, wd, wo, c, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_saturation();
    test_collision();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
